exec_unit: RTL and testbench
============================

EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 SHALL have parameter DATA_LEN, default 8, datapath and stack word width.
REQ-002 SHALL have parameter ADDR_LEN, default 8, data-memory address width.
REQ-003 SHALL have parameter INST_CAP, default 20, instruction count; PC_W = $clog2(INST_CAP)+1.
REQ-004 SHALL have parameter STK_DEPTH, default 16, internal stack entries; SP_W = $clog2(STK_DEPTH)+1.
REQ-005 SHALL have ports, in order:
- clk  in  1  single clock, rising edge
- rstn  in  1  asynchronous active-low reset
- en  in  1  global enable; low freezes all state
- inst_valid  in  1  instruction present
- inst_ready  out  1  unit accepts instruction this cycle
- control_bus  in  4  opcode
- addr_const  in  DATA_LEN  immediate / memory address / jump target
- mem_addr  out  ADDR_LEN  registered memory address (addr_const[ADDR_LEN-1:0])
- mem_r_en, mem_w_en  out  1  registered memory strobes
- mem_data_in  out  DATA_LEN  store data
- mem_data_out  in  DATA_LEN  load data
- mem_ready  in  1  memory completes access this cycle
- pc  out  PC_W  program counter
- sp  out  SP_W  stack occupancy, 0..STK_DEPTH
- tos  out  DATA_LEN  top of stack; 0 when sp=0
- halted, error  out  1  sticky status
- err_code  out  2  01 overflow, 10 underflow, 11 illegal opcode/target

Function
REQ-006 SHALL implement states IDLE, MEM, HALT, ERR.
REQ-007 SHALL drive inst_ready = en AND state==IDLE; accept occurs when inst_valid AND inst_ready at a rising edge.
REQ-008 SHALL execute opcodes 0 NOP, 1 PUSHC (push addr_const), 4 ADD, 5 SUB, 6 AND, 7 OR, 8 NOT, 9 JMP, 10 JZ, 11 JS, 12 DUP entirely at the accepting edge, remaining in IDLE.
REQ-009 SHALL for binary ops pop two, push one: result = NOS op TOS, SUB = NOS - TOS, modulo 2^DATA_LEN; NOT replaces TOS with ~TOS; sp net -1 for binary, 0 for NOT, +1 for DUP/PUSHC.
REQ-010 SHALL for JZ/JS pop TOS and set pc=addr_const if TOS==0 (JZ) / TOS[DATA_LEN-1]==1 (JS), else pc+1; JMP sets pc=addr_const without stack access.
REQ-011 SHALL for all non-branching accepted instructions set pc = pc+1, wrapping INST_CAP-1 -> 0.
REQ-012 SHALL on opcode 2 LOAD / 3 STORE go to MEM, register mem_addr, assert mem_r_en (LOAD) or mem_w_en with mem_data_in=TOS (STORE) from the next cycle until the mem_ready cycle inclusive.
REQ-013 SHALL in MEM at the edge where mem_ready=1: LOAD pushes mem_data_out, STORE pops TOS, pc+1, strobes deassert, return to IDLE; minimum LOAD/STORE latency 2 cycles accept-to-IDLE.
REQ-014 SHALL check faults at accept: push with sp==STK_DEPTH -> 01; pop needing more entries than sp -> 10 (binary/DUP need 2/1, JZ/JS/NOT/STORE need 1); opcodes 13,14 or jump target >= INST_CAP -> 11.
REQ-015 SHALL on fault leave pc, sp, stack contents unchanged, set error, latch err_code, enter ERR; ERR is terminal until reset.
REQ-016 SHALL on opcode 15 HALT set halted, keep pc unchanged, enter HALT; terminal until reset.
REQ-017 SHALL when en=0 hold all registers and outputs, ignore inst_valid and mem_ready; strobes in MEM stay asserted.
REQ-018 SHALL evaluate faults for LOAD (push) at accept, not at completion, so a full stack never issues a read.

Reset
REQ-019 SHALL on rstn low immediately set state IDLE, pc=0, sp=0, tos=0, mem_r_en=mem_w_en=0, mem_addr=0, mem_data_in=0, halted=0, error=0, err_code=00, independent of clk and en, including mid-MEM access.
REQ-020 SHALL not require clearing stack storage; tos SHALL read 0 while sp=0.

Verification
REQ-021 SHALL cover: PUSHC 5, PUSHC 3, SUB -> sp=1, tos=2, pc=3; PUSHC 3, PUSHC 5, SUB -> tos=8'hFE.
REQ-022 SHALL cover: PUSHC 0, JZ 7 -> pc=7, sp=0; PUSHC 8'h80, JS 19 -> pc=19; JMP 20 -> error, err_code=11, pc unchanged.
REQ-023 SHALL cover: LOAD 8'h10 with mem_ready after 3 wait cycles -> mem_r_en high 4 cycles, mem_addr=8'h10, then tos=mem_data_out, sp+1, inst_ready back high.
REQ-024 SHALL cover: 16 PUSHC then PUSHC -> err_code=01, sp=16, inst_ready=0; ADD on empty stack -> err_code=10, sp=0.
REQ-025 SHALL cover: en low during MEM with mem_ready high -> no completion; rstn low mid-STORE -> strobes 0 asynchronously, pc=0, sp=0.
REQ-026 SHALL cover: pc wrap: 20 NOPs -> pc=0; HALT -> halted=1, further inst_valid ignored, pc unchanged.

Source files
------------

// File: rtl/exec_unit.sv
// Stack-machine execution unit: single-cycle ALU/branch ops, multi-cycle LOAD/STORE,
// sticky HALT and ERR terminal states with asynchronous active-low reset.
module exec_unit #(
  parameter int DATA_LEN  = 8,
  parameter int ADDR_LEN  = 8,
  parameter int INST_CAP  = 20,
  parameter int STK_DEPTH = 16,
  parameter int PC_W      = $clog2(INST_CAP) + 1,
  parameter int SP_W      = $clog2(STK_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                en,
  input  logic                inst_valid,
  output logic                inst_ready,
  input  logic [3:0]          control_bus,
  input  logic [DATA_LEN-1:0] addr_const,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic                mem_r_en,
  output logic                mem_w_en,
  output logic [DATA_LEN-1:0] mem_data_in,
  input  logic [DATA_LEN-1:0] mem_data_out,
  input  logic                mem_ready,
  output logic [PC_W-1:0]     pc,
  output logic [SP_W-1:0]     sp,
  output logic [DATA_LEN-1:0] tos,
  output logic                halted,
  output logic                error,
  output logic [1:0]          err_code
);

  localparam int AW = $clog2(STK_DEPTH);

  localparam logic [1:0] IDLE = 2'd0, MEM = 2'd1, HALT = 2'd2, ERR = 2'd3;

  localparam logic [3:0] OP_NOP = 4'd0, OP_PUSHC = 4'd1, OP_LOAD = 4'd2, OP_STORE = 4'd3,
                         OP_ADD = 4'd4, OP_SUB = 4'd5, OP_AND = 4'd6, OP_OR = 4'd7,
                         OP_NOT = 4'd8, OP_JMP = 4'd9, OP_JZ = 4'd10, OP_JS = 4'd11,
                         OP_DUP = 4'd12, OP_HALT = 4'd15;

  logic [1:0]          state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [SP_W-1:0]     sp_q, sp_d;
  logic                memRen_q, memRen_d, memWen_q, memWen_d;
  logic [ADDR_LEN-1:0] memAddr_q, memAddr_d;
  logic [DATA_LEN-1:0] memData_q, memData_d;
  logic                halted_q, halted_d, error_q, error_d;
  logic [1:0]          errCode_q, errCode_d;

  logic [DATA_LEN-1:0] stack_q [STK_DEPTH];
  logic                stkWe;
  logic [AW-1:0]       stkIdx;
  logic [DATA_LEN-1:0] stkWdata;

  logic [AW-1:0]       spIdx, spM1, spM2;
  logic [DATA_LEN-1:0] nos, aluRes;
  logic [PC_W-1:0]     pcInc, tgt;
  logic                tgtBad, isPush, needOne, needTwo, isJump;
  logic [1:0]          fault;

  assign spIdx = sp_q[AW-1:0];
  assign spM1  = spIdx - 1'b1;
  assign spM2  = spIdx - 2'd2;
  assign tos   = (sp_q == '0) ? '0 : stack_q[spM1];
  assign nos   = stack_q[spM2];

  assign pcInc  = (pc_q == PC_W'(INST_CAP - 1)) ? '0 : pc_q + 1'b1;
  assign tgt    = addr_const[PC_W-1:0];
  assign tgtBad = ({1'b0, addr_const} >= (DATA_LEN+1)'(INST_CAP));

  assign isPush  = (control_bus == OP_PUSHC) || (control_bus == OP_DUP) || (control_bus == OP_LOAD);
  assign needTwo = (control_bus >= OP_ADD) && (control_bus <= OP_OR);
  assign needOne = (control_bus == OP_NOT) || (control_bus == OP_JZ) || (control_bus == OP_JS) ||
                   (control_bus == OP_STORE) || (control_bus == OP_DUP);
  assign isJump  = (control_bus == OP_JMP) || (control_bus == OP_JZ) || (control_bus == OP_JS);

  always_comb begin
    fault = 2'b00;
    if (control_bus == 4'd13 || control_bus == 4'd14 || (isJump && tgtBad)) fault = 2'b11;
    else if (needTwo && sp_q < SP_W'(2))                                     fault = 2'b10;
    else if (needOne && sp_q == '0)                                          fault = 2'b10;
    else if (isPush && sp_q == SP_W'(STK_DEPTH))                             fault = 2'b01;
  end

  always_comb begin
    aluRes = '0;
    case (control_bus)
      OP_ADD:  aluRes = nos + tos;
      OP_SUB:  aluRes = nos - tos;
      OP_AND:  aluRes = nos & tos;
      OP_OR:   aluRes = nos | tos;
      default: aluRes = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    sp_d      = sp_q;
    memRen_d  = memRen_q;
    memWen_d  = memWen_q;
    memAddr_d = memAddr_q;
    memData_d = memData_q;
    halted_d  = halted_q;
    error_d   = error_q;
    errCode_d = errCode_q;
    stkWe     = 1'b0;
    stkIdx    = '0;
    stkWdata  = '0;
    if (en) begin
      if (state_q == IDLE && inst_valid) begin
        // Faults are resolved before any state change so a faulting instruction leaves no trace.
        if (fault != 2'b00) begin
          error_d   = 1'b1;
          errCode_d = fault;
          state_d   = ERR;
        end else begin
          case (control_bus)
            OP_PUSHC: begin
              stkWe = 1'b1; stkIdx = spIdx; stkWdata = addr_const;
              sp_d = sp_q + 1'b1; pc_d = pcInc;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
              stkWe = 1'b1; stkIdx = spM2; stkWdata = aluRes;
              sp_d = sp_q - 1'b1; pc_d = pcInc;
            end
            OP_NOT: begin
              stkWe = 1'b1; stkIdx = spM1; stkWdata = ~tos; pc_d = pcInc;
            end
            OP_DUP: begin
              stkWe = 1'b1; stkIdx = spIdx; stkWdata = tos;
              sp_d = sp_q + 1'b1; pc_d = pcInc;
            end
            OP_JMP: pc_d = tgt;
            OP_JZ: begin
              sp_d = sp_q - 1'b1;
              pc_d = (tos == '0) ? tgt : pcInc;
            end
            OP_JS: begin
              sp_d = sp_q - 1'b1;
              pc_d = tos[DATA_LEN-1] ? tgt : pcInc;
            end
            OP_LOAD: begin
              state_d = MEM; memRen_d = 1'b1; memAddr_d = addr_const[ADDR_LEN-1:0];
            end
            OP_STORE: begin
              state_d = MEM; memWen_d = 1'b1; memAddr_d = addr_const[ADDR_LEN-1:0];
              memData_d = tos;
            end
            OP_HALT: begin
              halted_d = 1'b1; state_d = HALT;
            end
            default: pc_d = pcInc;
          endcase
        end
      end else if (state_q == MEM && mem_ready) begin
        memRen_d = 1'b0;
        memWen_d = 1'b0;
        pc_d     = pcInc;
        state_d  = IDLE;
        if (memRen_q) begin
          stkWe = 1'b1; stkIdx = spIdx; stkWdata = mem_data_out;
          sp_d = sp_q + 1'b1;
        end else begin
          sp_d = sp_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      sp_q      <= '0;
      memRen_q  <= 1'b0;
      memWen_q  <= 1'b0;
      memAddr_q <= '0;
      memData_q <= '0;
      halted_q  <= 1'b0;
      error_q   <= 1'b0;
      errCode_q <= 2'b00;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      sp_q      <= sp_d;
      memRen_q  <= memRen_d;
      memWen_q  <= memWen_d;
      memAddr_q <= memAddr_d;
      memData_q <= memData_d;
      halted_q  <= halted_d;
      error_q   <= error_d;
      errCode_q <= errCode_d;
    end
  end

  // Stack storage needs no reset: tos is masked to zero while the stack is empty.
  always_ff @(posedge clk) begin
    if (stkWe) stack_q[stkIdx] <= stkWdata;
  end

  assign inst_ready  = en && (state_q == IDLE);
  assign mem_addr    = memAddr_q;
  assign mem_r_en    = memRen_q;
  assign mem_w_en    = memWen_q;
  assign mem_data_in = memData_q;
  assign pc          = pc_q;
  assign sp          = sp_q;
  assign halted      = halted_q;
  assign error       = error_q;
  assign err_code    = errCode_q;

endmodule

// File: tb/tb_exec_unit.sv
// Directed-vector bench for exec_unit; inputs change and outputs are sampled on the falling edge.
module tb_exec_unit;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       en = 1'b1;
  logic       inst_valid = 1'b0;
  logic       inst_ready;
  logic [3:0] control_bus = 4'd0;
  logic [7:0] addr_const = 8'd0;
  logic [7:0] mem_addr;
  logic       mem_r_en, mem_w_en;
  logic [7:0] mem_data_in;
  logic [7:0] mem_data_out = 8'd0;
  logic       mem_ready = 1'b0;
  logic [5:0] pc;
  logic [4:0] sp;
  logic [7:0] tos;
  logic       halted, error;
  logic [1:0] err_code;

  int checks = 0;
  int errors = 0;
  int rCount;

  exec_unit dut (
    .clk(clk), .rstn(rstn), .en(en), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .control_bus(control_bus), .addr_const(addr_const), .mem_addr(mem_addr),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_ready(mem_ready), .pc(pc), .sp(sp), .tos(tos),
    .halted(halted), .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one instruction for exactly one rising edge, ending on the next falling edge.
  task automatic applyStimulus(input logic [3:0] op, input logic [7:0] k);
    control_bus = op;
    addr_const  = k;
    inst_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inst_valid  = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rstn = 1'b0; en = 1'b1; inst_valid = 1'b0; mem_ready = 1'b0;
    #2 rstn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #3;
    checkOutput("rst_pc", pc, 0);
    checkOutput("rst_sp", sp, 0);
    checkOutput("rst_tos", tos, 0);
    checkOutput("rst_err", {error, halted, mem_r_en, mem_w_en, err_code}, 0);
    doReset();
    checkOutput("rst_ready", inst_ready, 1);

    applyStimulus(4'd1, 8'd5);
    applyStimulus(4'd1, 8'd3);
    applyStimulus(4'd5, 8'd0);
    checkOutput("sub_sp", sp, 1);
    checkOutput("sub_tos", tos, 2);
    checkOutput("sub_pc", pc, 3);

    doReset();
    applyStimulus(4'd1, 8'd3);
    applyStimulus(4'd1, 8'd5);
    applyStimulus(4'd5, 8'd0);
    checkOutput("subneg_tos", tos, 8'hFE);
    applyStimulus(4'd1, 8'h0F);
    applyStimulus(4'd6, 8'd0);
    checkOutput("and_tos", tos, 8'h0E);
    applyStimulus(4'd1, 8'h31);
    applyStimulus(4'd7, 8'd0);
    checkOutput("or_tos", tos, 8'h3F);
    applyStimulus(4'd8, 8'd0);
    checkOutput("not_tos", tos, 8'hC0);
    applyStimulus(4'd12, 8'd0);
    checkOutput("dup_sp", sp, 2);
    applyStimulus(4'd4, 8'd0);
    checkOutput("add_tos", tos, 8'h80);
    checkOutput("add_sp", sp, 1);
    checkOutput("alu_pc", pc, 10);

    doReset();
    applyStimulus(4'd1, 8'd0);
    applyStimulus(4'd10, 8'd7);
    checkOutput("jz_pc", pc, 7);
    checkOutput("jz_sp", sp, 0);
    applyStimulus(4'd1, 8'd1);
    applyStimulus(4'd10, 8'd3);
    checkOutput("jz_nt_pc", pc, 9);
    applyStimulus(4'd1, 8'h80);
    applyStimulus(4'd11, 8'd19);
    checkOutput("js_pc", pc, 19);
    checkOutput("js_sp", sp, 0);
    applyStimulus(4'd9, 8'd20);
    checkOutput("jmp_err", error, 1);
    checkOutput("jmp_code", err_code, 2'b11);
    checkOutput("jmp_pc", pc, 19);
    checkOutput("err_ready", inst_ready, 0);

    doReset();
    applyStimulus(4'd13, 8'd0);
    checkOutput("illop_code", err_code, 2'b11);

    doReset();
    applyStimulus(4'd1, 8'd1);
    applyStimulus(4'd2, 8'h10);
    checkOutput("ld_addr", mem_addr, 8'h10);
    checkOutput("ld_ready", inst_ready, 0);
    rCount = 0;
    for (int c = 0; c < 3; c++) begin
      if (mem_r_en) rCount++;
      @(negedge clk);
    end
    mem_ready = 1'b1; mem_data_out = 8'h5A;
    if (mem_r_en) rCount++;
    @(negedge clk);
    mem_ready = 1'b0;
    checkOutput("ld_rcycles", rCount, 4);
    checkOutput("ld_ren_off", mem_r_en, 0);
    checkOutput("ld_tos", tos, 8'h5A);
    checkOutput("ld_sp", sp, 2);
    checkOutput("ld_pc", pc, 2);
    checkOutput("ld_ready_back", inst_ready, 1);

    applyStimulus(4'd3, 8'h22);
    checkOutput("st_wen", mem_w_en, 1);
    checkOutput("st_data", mem_data_in, 8'h5A);
    en = 1'b0; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("st_frozen_wen", mem_w_en, 1);
    checkOutput("st_frozen_sp", sp, 2);
    checkOutput("st_frozen_ready", inst_ready, 0);
    en = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    checkOutput("st_done_wen", mem_w_en, 0);
    checkOutput("st_sp", sp, 1);
    checkOutput("st_tos", tos, 1);
    checkOutput("st_pc", pc, 3);

    applyStimulus(4'd3, 8'h30);
    #2 rstn = 1'b0;
    #1;
    checkOutput("arst_wen", mem_w_en, 0);
    checkOutput("arst_pc", pc, 0);
    checkOutput("arst_sp", sp, 0);
    checkOutput("arst_addr", mem_addr, 0);
    doReset();

    for (int i = 0; i < 16; i++) applyStimulus(4'd1, 8'(i));
    checkOutput("full_sp", sp, 16);
    checkOutput("full_tos", tos, 15);
    applyStimulus(4'd1, 8'd99);
    checkOutput("ovf_code", err_code, 2'b01);
    checkOutput("ovf_sp", sp, 16);
    checkOutput("ovf_ready", inst_ready, 0);
    checkOutput("ovf_pc", pc, 16);

    doReset();
    applyStimulus(4'd4, 8'd0);
    checkOutput("udf_code", err_code, 2'b10);
    checkOutput("udf_sp", sp, 0);

    doReset();
    for (int i = 0; i < 19; i++) applyStimulus(4'd0, 8'd0);
    checkOutput("nop_pc19", pc, 19);
    applyStimulus(4'd0, 8'd0);
    checkOutput("wrap_pc", pc, 0);
    en = 1'b0;
    applyStimulus(4'd1, 8'd7);
    en = 1'b1;
    checkOutput("en_low_sp", sp, 0);
    applyStimulus(4'd15, 8'd0);
    checkOutput("halt_flag", halted, 1);
    checkOutput("halt_ready", inst_ready, 0);
    applyStimulus(4'd1, 8'd4);
    checkOutput("halt_pc", pc, 0);
    checkOutput("halt_sp", sp, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
